// File: rtl/vga_stream_timing_out.sv
// vga_stream_timing_out
// ---------------------
// Converts an Avalon-ST pixel stream into a VGA raster (hsync, vsync, blank, RGB).
// The raster stays idle until the PLL lock indication, re-synchronised into
// the pixel clock domain, is high. Incoming frames are aligned to the raster
// origin (h=0, v=0) using startofpacket.
//
// Ports:
//   clk              pixel clock
//   reset            synchronous, active-high reset
//   pll_locked       PLL lock indication, asynchronous to clk
//   in_data          pixel {R,G,B}, R in the most significant bits
//   in_valid         stream valid
//   in_startofpacket first pixel of a frame
//   in_endofpacket   last pixel of a frame (informational only)
//   in_ready         stream ready
//   vga_r/g/b        colour outputs, forced to 0 while blanked
//   vga_hs, vga_vs   active-low sync pulses
//   vga_blank_n      low outside the active region
//   vga_sync_n       constant 1
//   underflow        sticky: an active pixel slot found no valid data
module vga_stream_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pll_locked,
    input  logic [3*CW-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_startofpacket,
    input  logic            in_endofpacket,
    output logic            in_ready,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic            vga_sync_n,
    output logic            underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ZERO = HW'(0);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_ZERO = VW'(0);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        ALIGN     = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t            state_q;
    logic              sync1_q;
    logic              lock_s_q;
    logic [HW-1:0]     h_cnt_q;
    logic [VW-1:0]     v_cnt_q;
    logic              hs_q;
    logic              vs_q;
    logic              blank_n_q;
    logic [3*CW-1:0]   rgb_q;
    logic              underflow_q;

    logic              active_s;
    logic              at_origin_s;
    logic              hs_low_s;
    logic              vs_low_s;
    logic              ready_s;
    logic              accept_s;
    logic              show_s;
    logic              unused_eop_s;

    // End-of-packet carries no behaviour; kept only so the port is consumed.
    assign unused_eop_s = in_endofpacket;

    // Raster decode of the current counter position.
    always_comb begin
        active_s    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        at_origin_s = (h_cnt_q == H_ZERO) && (v_cnt_q == V_ZERO);
        hs_low_s    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vs_low_s    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    end

    // Stream ready and pixel-display decisions; ready is combinational so a
    // sop beat can be held back until the raster origin in the same cycle.
    always_comb begin
        ready_s = 1'b0;
        show_s  = 1'b0;
        case (state_q)
            ALIGN: begin
                // Drain stale beats; a sop beat waits for the origin.
                ready_s = lock_s_q && (!(in_valid && in_startofpacket) || at_origin_s);
            end
            RUN: begin
                // A non-sop head at the origin means the stream has slipped.
                ready_s = lock_s_q && active_s && !(at_origin_s && !in_startofpacket);
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
        accept_s = in_valid && ready_s;
        if (state_q == ALIGN) begin
            show_s = accept_s && in_startofpacket && at_origin_s;
        end else if (state_q == RUN) begin
            // A sop beat off the origin is consumed but never displayed.
            show_s = accept_s && (!in_startofpacket || at_origin_s);
        end else begin
            show_s = 1'b0;
        end
    end

    // Lock synchroniser, raster counters, state machine and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            h_cnt_q     <= H_ZERO;
            v_cnt_q     <= V_ZERO;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_n_q   <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
            if ((state_q == WAIT_LOCK) || !lock_s_q) begin
                // Idle raster: either waiting for lock or lock just lost.
                h_cnt_q   <= H_ZERO;
                v_cnt_q   <= V_ZERO;
                hs_q      <= 1'b1;
                vs_q      <= 1'b1;
                blank_n_q <= 1'b0;
                rgb_q     <= '0;
                if ((state_q == WAIT_LOCK) && lock_s_q) begin
                    state_q <= ALIGN;
                end else begin
                    state_q <= WAIT_LOCK;
                end
            end else begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_q <= H_ZERO;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_q <= V_ZERO;
                    end else begin
                        v_cnt_q <= v_cnt_q + V_ONE;
                    end
                end else begin
                    h_cnt_q <= h_cnt_q + H_ONE;
                end
                hs_q      <= !hs_low_s;
                vs_q      <= !vs_low_s;
                blank_n_q <= active_s;
                // show_s implies an active slot, so blanking forces RGB=0.
                rgb_q     <= show_s ? in_data : '0;
                if ((state_q == RUN) && active_s && !in_valid) begin
                    underflow_q <= 1'b1;
                end else begin
                    underflow_q <= underflow_q;
                end
                case (state_q)
                    ALIGN: begin
                        if (accept_s && in_startofpacket && at_origin_s) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= ALIGN;
                        end
                    end
                    RUN: begin
                        if (accept_s && in_startofpacket && !at_origin_s) begin
                            state_q <= ALIGN;
                        end else if (at_origin_s && in_valid && !in_startofpacket) begin
                            state_q <= ALIGN;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    assign in_ready    = ready_s;
    assign vga_r       = rgb_q[3*CW-1:2*CW];
    assign vga_g       = rgb_q[2*CW-1:CW];
    assign vga_b       = rgb_q[CW-1:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b1;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_stream_timing_out.sv
module tb_vga_stream_timing_out;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int CW = 10;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FR = HT * VT;             // 250

    localparam int M_WAIT  = 0;
    localparam int M_ALIGN = 1;
    localparam int M_RUN   = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pll_locked = 1'b0;
    logic [3*CW-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_startofpacket = 1'b0;
    logic            in_endofpacket = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   vga_r, vga_g, vga_b;
    logic            vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow;

    vga_stream_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked),
        .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_ready(in_ready), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pending stream beats: {sop, pixel}.
    logic [3*CW:0] q[$];

    // Reference model: mode, raster position as a linear index into the frame,
    // lock history (lock seen by the design lags the pin by two clocks).
    int          mode = M_WAIT;
    int          pos = 0;
    bit          p1 = 1'b0, p2 = 1'b0;
    bit          uf = 1'b0;
    bit          armed = 1'b0;
    logic        e_hs, e_vs, e_bl;
    logic [3*CW-1:0] e_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < HA * VA; i++) begin
            q.push_back({(i == 0), 30'($urandom)});
        end
    endtask

    task automatic push_stale(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back({1'b0, 30'($urandom)});
        end
    endtask

    // One clock: check pins against last prediction, drive, predict.
    task automatic step(input bit rst, input bit pll, input int valid_pct);
        int  h, v;
        bit  lock, act, org, rdy, acc, show, sop;
        @(negedge clk);
        if (armed) begin
            chk("hs", vga_hs, e_hs);
            chk("vs", vga_vs, e_vs);
            chk("blank_n", vga_blank_n, e_bl);
            chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
            chk("underflow", underflow, uf);
            chk("sync_n", vga_sync_n, 1'b1);
        end
        reset = rst;
        pll_locked = pll;
        in_endofpacket = 1'($urandom_range(1));
        if (q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
            in_valid = 1'b1;
            {in_startofpacket, in_data} = q[0];
        end else begin
            in_valid = 1'b0;
            in_startofpacket = 1'b0;
            in_data = 30'($urandom);
        end
        #1;
        if (rst) begin
            mode = M_WAIT; pos = 0; uf = 1'b0; p1 = 1'b0; p2 = 1'b0;
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = '0;
            armed = 1'b1;
        end else begin
            lock = p2; p2 = p1; p1 = pll;
            h = pos % HT; v = pos / HT;
            act = (h < HA) && (v < VA);
            org = (pos == 0);
            sop = in_startofpacket;
            rdy = 1'b0; show = 1'b0;
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = '0;
            if (mode == M_WAIT) begin
                if (lock) mode = M_ALIGN;
                pos = 0;
            end else if (!lock) begin
                mode = M_WAIT;
                pos = 0;
            end else begin
                if (mode == M_ALIGN) rdy = !(in_valid && sop) || org;
                else                 rdy = act && !(org && !sop);
                acc = in_valid && rdy;
                e_hs = !(h >= HA + HF && h < HA + HF + HS);
                e_vs = !(v >= VA + VF && v < VA + VF + VS);
                e_bl = act;
                if (mode == M_RUN && act && !in_valid) uf = 1'b1;
                if (mode == M_ALIGN) begin
                    if (acc && sop && org) begin
                        mode = M_RUN;
                        show = 1'b1;
                    end
                end else begin
                    if (acc && sop && !org) begin
                        mode = M_ALIGN;
                    end else begin
                        show = acc;
                        if (org && in_valid && !sop) mode = M_ALIGN;
                    end
                end
                if (show) e_rgb = in_data;
                if (acc) void'(q.pop_front());
                pos = (pos + 1) % FR;
            end
            chk("in_ready", in_ready, rdy);
        end
    endtask

    task automatic run(input int n, input bit pll, input int valid_pct);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) push_frame();
            step(1'b0, pll, valid_pct);
        end
    endtask

    initial begin
        // Reset with PLL unlocked; stale beats plus a frame are already queued.
        push_stale(3);
        push_frame();
        repeat (4) step(1'b1, 1'b0, 100);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 100);

        // Lock, fully valid stream: stale beats drained, frames aligned at origin.
        run(3 * FR, 1'b1, 100);

        // Random gaps in valid: underflow and slipped frames re-aligning.
        run(2 * FR, 1'b1, 93);

        // A new frame's sop arrives mid-frame.
        run(37, 1'b1, 100);
        q.delete();
        push_frame();
        run(2 * FR, 1'b1, 100);

        // Lock lost mid-line, then regained.
        run(113, 1'b1, 100);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 100);
        run(2 * FR + 40, 1'b1, 100);

        // Reset mid-frame with the stream still busy, then clean running.
        run(71, 1'b1, 100);
        repeat (2) step(1'b1, 1'b1, 100);
        run(3 * FR, 1'b1, 100);

        // Long random-valid stretch.
        run(3 * FR, 1'b1, 85);
        step(1'b0, 1'b1, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
